// File: rtl/branch_resolve_queue_if.sv
// Predictor-to-queue handshake plus the resolution and update-packet bus of branch_resolve_queue.
// The master modport is the predictor/resolution side, and the slave modport is the queue.
interface branch_resolve_queue_if #(
    parameter int M = 2
);
    logic          pred_valid;
    logic          pred_ready;
    logic [31:0]   pred_pc;
    logic          pred_taken;
    logic [M-1:0]  pred_ghr;
    logic          res_valid;
    logic          res_taken;
    logic          upd_valid;
    logic [31:0]   upd_pc;
    logic          upd_taken;
    logic [M-1:0]  upd_ghr;
    logic          upd_mispredict;
    logic          flush;

    modport master (
        output pred_valid, pred_pc, pred_taken, pred_ghr, res_valid, res_taken,
        input  pred_ready, upd_valid, upd_pc, upd_taken, upd_ghr, upd_mispredict, flush
    );

    modport slave (
        input  pred_valid, pred_pc, pred_taken, pred_ghr, res_valid, res_taken,
        output pred_ready, upd_valid, upd_pc, upd_taken, upd_ghr, upd_mispredict, flush
    );
endinterface

// File: rtl/branch_resolve_queue.sv
// In-order queue of in-flight branch predictions that emits registered update packets and flushes on a mispredict.
// Defining BRQ_STATS_EN builds the saturating correct/total resolution counters; otherwise both counters read as 0.
module branch_resolve_queue #(
    parameter int M     = 2,
    parameter int DEPTH = 4,
    parameter int CNT_W = 32
) (
    input  logic                         i_clk,
    input  logic                         i_reset,
    branch_resolve_queue_if.slave        brq,
    output logic [$clog2(DEPTH+1)-1:0]   o_count,
    output logic [CNT_W-1:0]             o_correct_cnt,
    output logic [CNT_W-1:0]             o_total_cnt
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [31:0]   r_pc  [DEPTH];
    logic          r_tk  [DEPTH];
    logic [M-1:0]  r_ghr [DEPTH];
    logic [PW-1:0] r_head, r_tail;
    logic [CW-1:0] r_count;

    logic          r_upd_valid, r_upd_taken, r_upd_mis, r_flush;
    logic [31:0]   r_upd_pc;
    logic [M-1:0]  r_upd_ghr;

    logic w_ready, w_push, w_pop, w_mis;

    assign w_ready = (r_count < CW'(DEPTH)) && !i_reset;
    assign w_push  = brq.pred_valid && w_ready;
    assign w_pop   = brq.res_valid && (r_count != '0);
    assign w_mis   = w_pop && (r_tk[r_head] != brq.res_taken);

    // A push that coincides with a mispredict is dropped, so the write is gated too.
    always_ff @(posedge i_clk) begin
        if (w_push && !w_mis) begin
            r_pc[r_tail]  <= brq.pred_pc;
            r_tk[r_tail]  <= brq.pred_taken;
            r_ghr[r_tail] <= brq.pred_ghr;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_head      <= '0;
            r_tail      <= '0;
            r_count     <= '0;
            r_upd_valid <= 1'b0;
            r_upd_taken <= 1'b0;
            r_upd_mis   <= 1'b0;
            r_upd_pc    <= '0;
            r_upd_ghr   <= '0;
            r_flush     <= 1'b0;
        end else begin
            r_upd_valid <= w_pop;
            r_flush     <= w_mis;
            if (w_pop) begin
                r_upd_pc    <= r_pc[r_head];
                r_upd_ghr   <= r_ghr[r_head];
                r_upd_taken <= brq.res_taken;
                r_upd_mis   <= w_mis;
            end
            if (w_mis) begin
                r_head  <= '0;
                r_tail  <= '0;
                r_count <= '0;
            end else begin
                if (w_push) r_tail <= r_tail + 1'b1;
                if (w_pop)  r_head <= r_head + 1'b1;
                r_count <= r_count + CW'(w_push) - CW'(w_pop);
            end
        end
    end

`ifdef BRQ_STATS_EN
    logic [CNT_W-1:0] r_correct_cnt, r_total_cnt;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_correct_cnt <= '0;
            r_total_cnt   <= '0;
        end else begin
            if (w_pop && (r_total_cnt != '1))
                r_total_cnt <= r_total_cnt + 1'b1;
            if (w_pop && !w_mis && (r_correct_cnt != '1))
                r_correct_cnt <= r_correct_cnt + 1'b1;
        end
    end

    assign o_correct_cnt = r_correct_cnt;
    assign o_total_cnt   = r_total_cnt;
`else
    assign o_correct_cnt = '0;
    assign o_total_cnt   = '0;
`endif

    assign brq.pred_ready     = w_ready;
    assign brq.upd_valid      = r_upd_valid;
    assign brq.upd_pc         = r_upd_pc;
    assign brq.upd_taken      = r_upd_taken;
    assign brq.upd_ghr        = r_upd_ghr;
    assign brq.upd_mispredict = r_upd_mis;
    assign brq.flush          = r_flush;
    assign o_count            = r_count;
endmodule

// File: tb/tb_branch_resolve_queue.sv
// Self-checking bench for branch_resolve_queue: directed scenarios followed by random traffic,
// all checked against a queue-based reference model.
module tb_branch_resolve_queue;
    localparam int M = 2;
    localparam int DEPTH = 4;
    localparam int CNT_W = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic [2:0]        count;
    logic [CNT_W-1:0]  correct_cnt, total_cnt;

    branch_resolve_queue_if #(.M(M)) brq_if ();

    branch_resolve_queue #(.M(M), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .i_clk         (clk),
        .i_reset       (reset),
        .brq           (brq_if.slave),
        .o_count       (count),
        .o_correct_cnt (correct_cnt),
        .o_total_cnt   (total_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]  pc;
        logic         tk;
        logic [M-1:0] ghr;
    } ent_t;

    ent_t        mq[$];
    logic        e_upd_valid, e_upd_taken, e_upd_mis, e_flush;
    logic [31:0] e_upd_pc;
    logic [M-1:0] e_upd_ghr;
    longint      e_correct, e_total;
    int          n_tests = 0;
    int          n_fail = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, advance the model across the edge, and compare afterwards.
    task automatic cycle(input logic rst, input logic pv, input logic [31:0] pc, input logic pt,
                         input logic [M-1:0] ghr, input logic rv, input logic rt);
        logic rdy, pop, push, mis;
        ent_t e;
        reset = rst;
        brq_if.pred_valid = pv;
        brq_if.pred_pc = pc;
        brq_if.pred_taken = pt;
        brq_if.pred_ghr = ghr;
        brq_if.res_valid = rv;
        brq_if.res_taken = rt;
        #1;
        rdy = (mq.size() < DEPTH) && !rst;
        check("pred_ready", brq_if.pred_ready, rdy);
        @(posedge clk);
        if (rst) begin
            mq.delete();
            e_upd_valid = 0; e_upd_taken = 0; e_upd_mis = 0; e_flush = 0;
            e_upd_pc = 0; e_upd_ghr = 0; e_correct = 0; e_total = 0;
        end else begin
            pop = rv && (mq.size() != 0);
            push = pv && rdy;
            mis = 0;
            e_upd_valid = pop;
            if (pop) begin
                e = mq.pop_front();
                mis = (e.tk != rt);
                e_upd_pc = e.pc; e_upd_ghr = e.ghr; e_upd_taken = rt; e_upd_mis = mis;
                e_total++;
                if (!mis) e_correct++;
            end
            e_flush = mis;
            if (mis) mq.delete();
            else if (push) mq.push_back('{pc, pt, ghr});
        end
        #1;
        check("count", count, mq.size());
        check("upd_valid", brq_if.upd_valid, e_upd_valid);
        check("flush", brq_if.flush, e_flush);
        check("upd_pc", brq_if.upd_pc, e_upd_pc);
        check("upd_ghr", brq_if.upd_ghr, e_upd_ghr);
        check("upd_taken", brq_if.upd_taken, e_upd_taken);
        check("upd_mispredict", brq_if.upd_mispredict, e_upd_mis);
`ifdef BRQ_STATS_EN
        check("correct_cnt", correct_cnt, e_correct);
        check("total_cnt", total_cnt, e_total);
`else
        check("correct_cnt", correct_cnt, 0);
        check("total_cnt", total_cnt, 0);
`endif
    endtask

    task automatic idle();
        cycle(0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        logic [31:0] pcs [4];
        logic        tks [4];
        logic        rt;

        pcs[0] = 32'h100; pcs[1] = 32'h104; pcs[2] = 32'h108; pcs[3] = 32'h10C;
        tks[0] = 1; tks[1] = 0; tks[2] = 1; tks[3] = 1;

        // 1: reset held two cycles
        cycle(1, 0, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0, 0);
        idle();

        // 2: fill, then a fifth push that must be refused
        for (int i = 0; i < 4; i++) cycle(0, 1, pcs[i], tks[i], M'(i), 0, 0);
        check("full_count", count, 4);
        cycle(0, 1, 32'hDEAD, 1, 0, 0, 0);

        // 3: resolve all four correctly
        for (int i = 0; i < 4; i++) begin
            cycle(0, 0, 0, 0, 0, 1, tks[i]);
            check("s3_pc", brq_if.upd_pc, pcs[i]);
            check("s3_ghr", brq_if.upd_ghr, i);
        end
        idle();

        // 6a: resolve with an empty queue
        cycle(0, 0, 0, 0, 0, 1, 1);

        // 4: mispredict with a simultaneous push of 0x200
        cycle(0, 1, 32'h300, 1, 1, 0, 0);
        cycle(0, 1, 32'h304, 1, 2, 0, 0);
        cycle(0, 1, 32'h308, 0, 3, 0, 0);
        cycle(0, 1, 32'h200, 1, 0, 1, 0);
        check("s4_flush", brq_if.flush, 1);
        check("s4_count", count, 0);
        idle();

        // 5: keep two entries in flight while the pointers wrap
        cycle(0, 1, 32'h400, 1, 0, 0, 0);
        cycle(0, 1, 32'h404, 0, 1, 0, 0);
        for (int i = 0; i < 10; i++) begin
            rt = mq[0].tk;
            cycle(0, 1, 32'h408 + 32'(4*i), i[0], M'(i), 1, rt);
            check("s5_count", count, 2);
            check("s5_pc", brq_if.upd_pc, 32'h400 + 32'(4*i));
        end

        // 6c: reset with three entries present
        cycle(0, 1, 32'h500, 1, 0, 0, 0);
        check("s6_count3", count, 3);
        cycle(1, 0, 0, 0, 0, 1, 1);
        check("s6_rst_count", count, 0);
        idle();

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            logic r, pv, pt, rv;
            r = ($urandom_range(0, 59) == 0);
            pv = ($urandom_range(0, 2) != 0);
            pt = $urandom_range(0, 1);
            rv = ($urandom_range(0, 1) == 1);
            if (mq.size() != 0 && $urandom_range(0, 4) != 0) rt = mq[0].tk;
            else rt = $urandom_range(0, 1);
            cycle(r, pv, $urandom, pt, M'($urandom_range(0, 3)), rv, rt);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end
endmodule

// File: doc/branch_resolve_queue.md
Name: branch_resolve_queue

Overview:
- Sits directly downstream of correlatingBranchPredictor.
- Buffers in-flight predictions (PC, predicted direction, global-history snapshot) in program order until each branch resolves.
- On resolution it emits a registered update packet back to the predictor tables, detects mispredicts and flushes younger entries.
- Keeps running correct/total prediction counts in hardware, so accuracy is measured in the design rather than only in a bench.

Parameters:
- M, 2, global-history snapshot width carried per entry (matches predictor M; M=0 not supported, use M>=1).
- DEPTH, 4, queue entries; power of two, >=2.
- CNT_W, 32, width of the statistics counters.

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous, active-high
- pred_valid  in  1  predictor presents a prediction this cycle
- pred_ready  out  1  queue can accept; combinational = (count < DEPTH) && !reset
- pred_pc  in  32  branch PC
- pred_taken  in  1  predicted direction (predictor's branch output)
- pred_ghr  in  M  history snapshot used for this prediction
- res_valid  in  1  oldest outstanding branch resolved this cycle
- res_taken  in  1  actual outcome (result)
- upd_valid  out  1  registered update packet valid, one-cycle pulse
- upd_pc  out  32  PC of resolved branch
- upd_taken  out  1  actual outcome
- upd_ghr  out  M  snapshot stored at enqueue
- upd_mispredict  out  1  stored prediction != actual outcome
- flush  out  1  one-cycle pulse, coincident with upd_valid && upd_mispredict
- count  out  $clog2(DEPTH+1)  current occupancy
- correct_cnt  out  CNT_W  correctly predicted resolutions
- total_cnt  out  CNT_W  total resolutions

Behaviour:
- Reset, synchronous, checked at the rising edge: head/tail pointers, count, upd_* outputs, flush and both counters = 0. pred_ready = 0 while reset is high and 1 on the first cycle after it drops. Reset asserted mid-operation discards all entries; no update is emitted for them.
- Storage: circular buffer with head/tail pointers that wrap modulo DEPTH. Entry = {pc, taken, ghr}.
- Push: pred_valid && pred_ready writes the entry at tail at the edge; tail++, count++.
- Pop: res_valid && count != 0 reads the head entry; head++, count-- at the edge.
- Pop output, next cycle (1-cycle latency, registered): upd_valid = 1, upd_pc/upd_ghr = entry fields, upd_taken = res_taken, upd_mispredict = (entry.taken != res_taken).
- res_valid with count == 0: ignored. No update, no counter change.
- Simultaneous push and pop, no mispredict: both occur and count is unchanged. When full, pred_ready stays 0 that cycle even though a pop occurs (no ready bypass).
- Mispredict:
  - On the pop edge, all remaining entries are discarded: head = tail = 0, count = 0.
  - A push in the same cycle is also discarded.
  - The next cycle shows flush = 1 together with upd_valid = 1 and upd_mispredict = 1.
  - The upstream stage re-steers on flush.
- Counters:
  - total_cnt += 1 on every valid pop.
  - correct_cnt += 1 on each valid pop without mispredict.
  - Both counters saturate at all-ones and never wrap.
  - Both update on the pop edge, so they are visible in the same cycle as upd_valid.
- upd_* fields hold their last value when upd_valid = 0; consumers qualify them with upd_valid.

Optional Feature:
- Macro: BRQ_STATS_EN.
- Defined: correct_cnt and total_cnt are implemented as described above.
- Undefined: no counter flops are built; correct_cnt and total_cnt are tied to 0. All other behaviour is identical.

Test Plan:
1. Reset held 2 cycles, then released -> count=0, pred_ready=1, upd_valid=0, correct_cnt=total_cnt=0.
2. Push 4 entries (pc 0x100/0x104/0x108/0x10C, taken 1/0/1/1, ghr 0..3) -> count=4, pred_ready=0. A 5th push attempt is not accepted.
3. Resolve 4 entries with outcomes 1/0/1/1, one per cycle -> four upd_valid pulses in order, upd_pc 0x100..0x10C, upd_ghr 0..3, upd_mispredict=0, correct_cnt=total_cnt=4.
4. Mispredict flush:
   - Setup: push 3 entries (taken 1/1/0).
   - Stimulus: resolve the first with res_taken=0 while pred_valid=1 (pc 0x200).
   - Required: next cycle upd_mispredict=1, flush=1, count=0, 0x200 not stored; correct_cnt unchanged, total_cnt +1.
5. Wrap and simultaneous push/pop:
   - Stimulus: after 10 mixed push/pop cycles (pointers wrap twice), perform a push and a correct pop in the same cycle with count=2.
   - Required: count stays 2, FIFO order preserved across the wrap.
6. Boundary and reset cases:
   - res_valid with an empty queue -> no upd_valid, counters unchanged.
   - With BRQ_STATS_EN undefined, scenario 3 gives correct_cnt=total_cnt=0.
   - reset asserted with count=3 -> count=0 next cycle, no upd_valid.
